cpu_reg_writeback: RTL and testbench



---
 rtl/cpu_reg_writeback.sv | 236 +++++++++++++++++++++++
 tb/tb_cpu_reg_writeback.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_reg_writeback.sv
// ---------------------------------------------------------------------------
// cpu_reg_writeback
//
// Architectural register file and status-flag stage that sits directly after
// the ALU datapath. On a commit strobe it writes the ALU result into A, X, Y
// or SP and updates the N/V/Z/C flags of P. It also handles PLP/RTI loads of
// P, explicit flag set/clear, and SP push/pull stepping. Every output comes
// straight from a flop, so there is no input-to-output combinational path.
//
// Parameters:
//   SP_RESET  stack pointer value after reset
//   P_RESET   status register value after reset (bit 5 reads 1, bit 4 reads 0)
//
// Ports:
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   alu_out/alu_cout  ALU result and carry out
//   op_a7/op_b7       sign bits of the ALU operands (V computation)
//   op_sub            ALU inverted operand B (SBC/CMP)
//   wr_en             commit strobe
//   dest_select       0 none, 1 A, 2 X, 3 Y, 4 SP, 5-7 none
//   flag_mask         {N,V,Z,C} enables for the commit
//   p_load/mem_in     load P from the data bus
//   flag_set/clr/sel  force one flag (0 C, 1 I, 2 D, 3 V) to 1 / 0
//   sp_inc/sp_dec     stack pointer pull / push step
//   a_reg,x_reg,y_reg,sp  architectural registers
//   p_out             {N,V,1,0,D,I,Z,C}
//   carry_out         registered C flag, the ALU carry-in
//
// Configuration macro:
//   DECIMAL_FLAG_EN   when defined the D flag is stored and writable; when
//                     undefined D is hardwired to 0.
// ---------------------------------------------------------------------------
module cpu_reg_writeback #(
  parameter logic [7:0] SP_RESET = 8'hFD,
  parameter logic [7:0] P_RESET  = 8'h24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] alu_out,
  input  logic       alu_cout,
  input  logic       op_a7,
  input  logic       op_b7,
  input  logic       op_sub,
  input  logic       wr_en,
  input  logic [2:0] dest_select,
  input  logic [3:0] flag_mask,
  input  logic       p_load,
  input  logic [7:0] mem_in,
  input  logic       flag_set,
  input  logic       flag_clr,
  input  logic [1:0] flag_sel,
  input  logic       sp_inc,
  input  logic       sp_dec,
  output logic [7:0] a_reg,
  output logic [7:0] x_reg,
  output logic [7:0] y_reg,
  output logic [7:0] sp,
  output logic [7:0] p_out,
  output logic       carry_out
);

  localparam logic [2:0] DEST_A  = 3'd1;
  localparam logic [2:0] DEST_X  = 3'd2;
  localparam logic [2:0] DEST_Y  = 3'd3;
  localparam logic [2:0] DEST_SP = 3'd4;

  localparam logic [1:0] SEL_C = 2'd0;
  localparam logic [1:0] SEL_I = 2'd1;
  localparam logic [1:0] SEL_D = 2'd2;
  localparam logic [1:0] SEL_V = 2'd3;

  // Architectural registers
  logic [7:0] a_q,  a_d;
  logic [7:0] x_q,  x_d;
  logic [7:0] y_q,  y_d;
  logic [7:0] sp_q, sp_d;

  // Individual status flags (bits 5 and 4 of P are not storage)
  logic n_q, n_d;
  logic v_q, v_d;
  logic i_q, i_d;
  logic z_q, z_d;
  logic c_q, c_d;
  logic d_flag;

`ifdef DECIMAL_FLAG_EN
  logic d_q, d_d;
  assign d_flag = d_q;
`else
  // D reads as 0; the data-bus bit that would feed it is deliberately dropped.
  logic unused_mem_d;
  assign d_flag       = 1'b0;
  assign unused_mem_d = mem_in[3];
`endif

  // Flag values a commit would produce
  logic n_cmt, v_cmt, z_cmt, c_cmt;

  // Exactly one of set/clear asserted; both together is a no-op
  logic force_en;
  logic force_val;

  always_comb begin
    n_cmt = alu_out[7];
    z_cmt = (alu_out == 8'h00);
    c_cmt = alu_cout;
    // Overflow: operands (B after optional inversion) share a sign and the
    // result sign differs from it.
    v_cmt = (op_a7 == (op_b7 ^ op_sub)) && (alu_out[7] != op_a7);

    force_en  = flag_set ^ flag_clr;
    force_val = flag_set;
  end

  // -------------------------------------------------------------------------
  // Register next-state
  // -------------------------------------------------------------------------
  always_comb begin
    a_d = a_q;
    x_d = x_q;
    y_d = y_q;

    if (wr_en) begin
      case (dest_select)
        DEST_A:  a_d = alu_out;
        DEST_X:  x_d = alu_out;
        DEST_Y:  y_d = alu_out;
        default: ;
      endcase
    end
  end

  // SP: a commit targeting SP wins over stepping; inc+dec together cancel.
  always_comb begin
    sp_d = sp_q;
    if (wr_en && (dest_select == DEST_SP)) begin
      sp_d = alu_out;
    end else if (sp_inc && !sp_dec) begin
      sp_d = sp_q + 8'd1;
    end else if (sp_dec && !sp_inc) begin
      sp_d = sp_q - 8'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Flag next-state, applied lowest priority first so later layers override:
  // commit flags, then set/clear of one bit, then a full P load.
  // -------------------------------------------------------------------------
  always_comb begin
    n_d = n_q;
    v_d = v_q;
    i_d = i_q;
    z_d = z_q;
    c_d = c_q;
`ifdef DECIMAL_FLAG_EN
    d_d = d_q;
`endif

    // Commit: independent of dest_select (TXS relies on a zero mask).
    if (wr_en) begin
      if (flag_mask[3]) n_d = n_cmt;
      if (flag_mask[2]) v_d = v_cmt;
      if (flag_mask[1]) z_d = z_cmt;
      if (flag_mask[0]) c_d = c_cmt;
    end

    // Set/clear only touches the selected bit; other masked bits still update.
    if (force_en) begin
      case (flag_sel)
        SEL_C:   c_d = force_val;
        SEL_I:   i_d = force_val;
`ifdef DECIMAL_FLAG_EN
        SEL_D:   d_d = force_val;
`endif
        SEL_V:   v_d = force_val;
        default: ;
      endcase
    end

    // PLP/RTI: bits 5 and 4 of the bus are not stored.
    if (p_load) begin
      n_d = mem_in[7];
      v_d = mem_in[6];
`ifdef DECIMAL_FLAG_EN
      d_d = mem_in[3];
`endif
      i_d = mem_in[2];
      z_d = mem_in[1];
      c_d = mem_in[0];
    end
  end

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q  <= 8'h00;
      x_q  <= 8'h00;
      y_q  <= 8'h00;
      sp_q <= SP_RESET;
      n_q  <= P_RESET[7];
      v_q  <= P_RESET[6];
      i_q  <= P_RESET[2];
      z_q  <= P_RESET[1];
      c_q  <= P_RESET[0];
`ifdef DECIMAL_FLAG_EN
      d_q  <= P_RESET[3];
`endif
    end else begin
      a_q  <= a_d;
      x_q  <= x_d;
      y_q  <= y_d;
      sp_q <= sp_d;
      n_q  <= n_d;
      v_q  <= v_d;
      i_q  <= i_d;
      z_q  <= z_d;
      c_q  <= c_d;
`ifdef DECIMAL_FLAG_EN
      d_q  <= d_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Outputs (flops and constants only)
  // -------------------------------------------------------------------------
  assign a_reg     = a_q;
  assign x_reg     = x_q;
  assign y_reg     = y_q;
  assign sp        = sp_q;
  assign p_out     = {n_q, v_q, 1'b1, 1'b0, d_flag, i_q, z_q, c_q};
  assign carry_out = c_q;

endmodule

// File: tb/tb_cpu_reg_writeback.sv
module tb_cpu_reg_writeback;

  logic       clk;
  logic       rst_n;
  logic [7:0] alu_out;
  logic       alu_cout;
  logic       op_a7;
  logic       op_b7;
  logic       op_sub;
  logic       wr_en;
  logic [2:0] dest_select;
  logic [3:0] flag_mask;
  logic       p_load;
  logic [7:0] mem_in;
  logic       flag_set;
  logic       flag_clr;
  logic [1:0] flag_sel;
  logic       sp_inc;
  logic       sp_dec;
  logic [7:0] a_reg, x_reg, y_reg, sp, p_out;
  logic       carry_out;

  int checks = 0;
  int errors = 0;

  cpu_reg_writeback dut (
    .clk(clk), .rst_n(rst_n), .alu_out(alu_out), .alu_cout(alu_cout),
    .op_a7(op_a7), .op_b7(op_b7), .op_sub(op_sub), .wr_en(wr_en),
    .dest_select(dest_select), .flag_mask(flag_mask), .p_load(p_load),
    .mem_in(mem_in), .flag_set(flag_set), .flag_clr(flag_clr),
    .flag_sel(flag_sel), .sp_inc(sp_inc), .sp_dec(sp_dec),
    .a_reg(a_reg), .x_reg(x_reg), .y_reg(y_reg), .sp(sp),
    .p_out(p_out), .carry_out(carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst_n = 1'b1; alu_out = 8'h00; alu_cout = 1'b0;
    op_a7 = 1'b0; op_b7 = 1'b0; op_sub = 1'b0;
    wr_en = 1'b0; dest_select = 3'd0; flag_mask = 4'b0000;
    p_load = 1'b0; mem_in = 8'h00;
    flag_set = 1'b0; flag_clr = 1'b0; flag_sel = 2'd0;
    sp_inc = 1'b0; sp_dec = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    // Strobes during reset must be ignored
    rst_n = 1'b0; wr_en = 1'b1; dest_select = 3'd1; alu_out = 8'h55;
    flag_mask = 4'b1111; alu_cout = 1'b1; sp_dec = 1'b1; p_load = 1'b1; mem_in = 8'hFF;
    tick();
    idle();
    checks++; if (a_reg !== 8'h00) begin errors++; $display("FAIL reset_a got %h exp 00", a_reg); end
    checks++; if (x_reg !== 8'h00) begin errors++; $display("FAIL reset_x got %h exp 00", x_reg); end
    checks++; if (y_reg !== 8'h00) begin errors++; $display("FAIL reset_y got %h exp 00", y_reg); end
    checks++; if (sp !== 8'hFD) begin errors++; $display("FAIL reset_sp got %h exp FD", sp); end
    checks++; if (p_out !== 8'h24) begin errors++; $display("FAIL reset_p got %h exp 24", p_out); end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL reset_carry got %b exp 0", carry_out); end
  endtask

  task automatic test_commit_a();
    do_reset();
    wr_en = 1'b1; dest_select = 3'd1; alu_out = 8'h80; alu_cout = 1'b0; flag_mask = 4'b1010;
    tick();
    idle();
    checks++; if (a_reg !== 8'h80) begin errors++; $display("FAIL commit_a got %h exp 80", a_reg); end
    checks++; if (p_out !== 8'hA4) begin errors++; $display("FAIL commit_a_p got %h exp A4", p_out); end
  endtask

  task automatic test_overflow();
    do_reset();
    op_a7 = 1'b0; op_b7 = 1'b0; op_sub = 1'b0;
    wr_en = 1'b1; dest_select = 3'd1; alu_out = 8'h80; alu_cout = 1'b0; flag_mask = 4'b1111;
    tick();
    idle();
    checks++; if (p_out !== 8'hE4) begin errors++; $display("FAIL overflow_p got %h exp E4", p_out); end
    // Flags-only commit: negative+negative -> positive zero with carry.
    op_a7 = 1'b1; op_b7 = 1'b1; op_sub = 1'b0;
    wr_en = 1'b1; dest_select = 3'd0; alu_out = 8'h00; alu_cout = 1'b1; flag_mask = 4'b1111;
    tick();
    idle();
    checks++; if (p_out !== 8'h67) begin errors++; $display("FAIL carry_p got %h exp 67", p_out); end
    checks++; if (carry_out !== 1'b1) begin errors++; $display("FAIL carry_out got %b exp 1", carry_out); end
    checks++; if (a_reg !== 8'h80) begin errors++; $display("FAIL dest_none_a got %h exp 80", a_reg); end
    // Subtract: a7=0, b7=1 inverted -> 0; result 80 -> V=1. Only V masked.
    op_a7 = 1'b0; op_b7 = 1'b1; op_sub = 1'b1;
    wr_en = 1'b1; dest_select = 3'd7; alu_out = 8'h80; flag_mask = 4'b0100;
    tick();
    idle();
    checks++; if (p_out !== 8'h67) begin errors++; $display("FAIL sub_v_p got %h exp 67", p_out); end
    // Same, but no overflow: a7=1 vs inverted b7=0 differ -> V=0
    op_a7 = 1'b1; op_b7 = 1'b1; op_sub = 1'b1;
    wr_en = 1'b1; dest_select = 3'd5; alu_out = 8'h00; flag_mask = 4'b0100;
    tick();
    idle();
    checks++; if (p_out !== 8'h27) begin errors++; $display("FAIL sub_nov_p got %h exp 27", p_out); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    wr_en = 1'b1; dest_select = 3'd2; alu_out = 8'h12; flag_mask = 4'b0000;
    tick();
    dest_select = 3'd3; alu_out = 8'h34;
    tick();
    idle();
    checks++; if (x_reg !== 8'h12) begin errors++; $display("FAIL b2b_x got %h exp 12", x_reg); end
    checks++; if (y_reg !== 8'h34) begin errors++; $display("FAIL b2b_y got %h exp 34", y_reg); end
    checks++; if (p_out !== 8'h24) begin errors++; $display("FAIL b2b_p got %h exp 24", p_out); end
  endtask

  task automatic test_sp_wrap();
    do_reset();
    wr_en = 1'b1; dest_select = 3'd4; alu_out = 8'h00;
    tick();
    idle();
    checks++; if (sp !== 8'h00) begin errors++; $display("FAIL sp_commit got %h exp 00", sp); end
    sp_dec = 1'b1;
    tick();
    idle();
    checks++; if (sp !== 8'hFF) begin errors++; $display("FAIL sp_dec_wrap got %h exp FF", sp); end
    sp_inc = 1'b1;
    tick();
    idle();
    checks++; if (sp !== 8'h00) begin errors++; $display("FAIL sp_inc_wrap got %h exp 00", sp); end
    sp_inc = 1'b1; sp_dec = 1'b1;
    tick();
    idle();
    checks++; if (sp !== 8'h00) begin errors++; $display("FAIL sp_both got %h exp 00", sp); end
    sp_dec = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    idle();
    checks++; if (sp !== 8'hFD) begin errors++; $display("FAIL sp_dec3 got %h exp FD", sp); end
    wr_en = 1'b1; dest_select = 3'd4; alu_out = 8'h40; sp_inc = 1'b1;
    tick();
    idle();
    checks++; if (sp !== 8'h40) begin errors++; $display("FAIL sp_commit_prio got %h exp 40", sp); end
    wr_en = 1'b1; dest_select = 3'd1; alu_out = 8'h9A; sp_inc = 1'b1;
    tick();
    idle();
    checks++; if (a_reg !== 8'h9A) begin errors++; $display("FAIL a_with_step got %h exp 9A", a_reg); end
    checks++; if (sp !== 8'h41) begin errors++; $display("FAIL step_with_a got %h exp 41", sp); end
  endtask

  task automatic test_priority();
    logic [7:0] exp_ff;
    do_reset();
    p_load = 1'b1; mem_in = 8'hC3; flag_clr = 1'b1; flag_sel = 2'd0;
    wr_en = 1'b1; flag_mask = 4'b1111; alu_out = 8'h00; alu_cout = 1'b0;
    tick();
    idle();
    checks++; if (p_out !== 8'hE3) begin errors++; $display("FAIL prio_pload got %h exp E3", p_out); end
    checks++; if (carry_out !== 1'b1) begin errors++; $display("FAIL prio_carry got %b exp 1", carry_out); end
    // set C overrides commit C only; N/V/Z still follow the commit
    wr_en = 1'b1; flag_mask = 4'b1111; alu_out = 8'h01; alu_cout = 1'b0;
    flag_set = 1'b1; flag_sel = 2'd0;
    tick();
    idle();
    checks++; if (p_out !== 8'h21) begin errors++; $display("FAIL prio_set_c got %h exp 21", p_out); end
    flag_set = 1'b1; flag_clr = 1'b1; flag_sel = 2'd1;
    tick();
    idle();
    checks++; if (p_out !== 8'h21) begin errors++; $display("FAIL set_clr_noop got %h exp 21", p_out); end
    flag_set = 1'b1; flag_sel = 2'd1;
    tick();
    flag_sel = 2'd3;
    tick();
    idle();
    checks++; if (p_out !== 8'h65) begin errors++; $display("FAIL set_i_v got %h exp 65", p_out); end
    flag_clr = 1'b1; flag_sel = 2'd3;
    tick();
    idle();
    checks++; if (p_out !== 8'h25) begin errors++; $display("FAIL clr_v got %h exp 25", p_out); end
    p_load = 1'b1; mem_in = 8'hFF;
    tick();
    idle();
`ifdef DECIMAL_FLAG_EN
    exp_ff = 8'hEF;
`else
    exp_ff = 8'hE7;
`endif
    checks++; if (p_out !== exp_ff) begin errors++; $display("FAIL pload_ff got %h exp %h", p_out, exp_ff); end
  endtask

  task automatic test_decimal();
    logic [7:0] exp_d;
    do_reset();
    flag_set = 1'b1; flag_sel = 2'd2;
    tick();
    idle();
`ifdef DECIMAL_FLAG_EN
    exp_d = 8'h2C;
`else
    exp_d = 8'h24;
`endif
    checks++; if (p_out !== exp_d) begin errors++; $display("FAIL decimal_set got %h exp %h", p_out, exp_d); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    sp_dec = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    idle();
    // FD -> FC, reset -> FD, resume -> FC
    checks++; if (sp !== 8'hFC) begin errors++; $display("FAIL reset_mid_sp got %h exp FC", sp); end
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    test_reset();
    test_commit_a();
    test_overflow();
    test_back_to_back();
    test_sp_wrap();
    test_priority();
    test_decimal();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
